// File: rtl/pca_train_ctrl.sv
// Training sequencer for the two-component Sanger GHA PCA core (16.16 fixed point).
// Gates samples into the core on a halving learning-rate schedule, detects convergence and drains the core.
module pca_train_ctrl #(
    parameter logic [31:0] MU_INIT     = 32'h0000_0CCC,
    parameter logic [31:0] MU_MIN      = 32'h0000_0040,
    parameter int          DECAY_LEN   = 1024,
    parameter int          MAX_SAMPLES = 65536,
    parameter logic [31:0] CONV_TH     = 32'h0000_0010,
    parameter int          CONV_CNT    = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic signed [31:0] s1_in,
    input  logic signed [31:0] s2_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] w11_in,
    input  logic signed [31:0] w12_in,
    input  logic signed [31:0] w21_in,
    input  logic signed [31:0] w22_in,
    output logic               core_rst,
    output logic signed [31:0] core_s1,
    output logic signed [31:0] core_s2,
    output logic signed [31:0] core_mu1,
    output logic signed [31:0] core_mu2,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic        [16:0] sample_cnt,
    output logic        [31:0] mu_cur
);
    localparam int DW = (DECAY_LEN > 1) ? $clog2(DECAY_LEN) : 1;
    localparam int QW = $clog2(CONV_CNT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR1, S_CLEAR2, S_TRAIN, S_DRAIN, S_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic        [1:0]   r_drain_cnt;
    logic                r_core_rst;
    logic                r_s_vld;
    logic signed [31:0]  r_core_s1, r_core_s2, r_core_mu, r_mu_hold;
    logic signed [31:0]  r_mu_cur;
    logic        [16:0]  r_sample_cnt;
    logic        [DW-1:0] r_decay;
    logic        [QW-1:0] r_quiet;
    logic        [2:0]   r_vpipe;
    logic                r_have_prev;
    logic                r_converged;
    logic signed [31:0]  r_w11_prev, r_w12_prev, r_w21_prev, r_w22_prev;

    logic                w_start, w_accept, w_max_hit, w_marked, w_all_quiet, w_conv_hit, w_abort_taken;
    logic signed [31:0]  w_mu_half, w_mu_next;

    function automatic logic is_quiet(input logic signed [31:0] w_new, input logic signed [31:0] w_old);
        logic signed [32:0] diff;
        logic        [32:0] mag;
        diff = $signed({w_new[31], w_new}) - $signed({w_old[31], w_old});
        mag  = diff[32] ? -diff : diff;
        return mag < {1'b0, CONV_TH};
    endfunction

    assign w_start       = (r_state == S_IDLE) && start;
    assign w_accept      = (r_state == S_TRAIN) && in_valid;
    assign w_max_hit     = w_accept && (r_sample_cnt == 17'(MAX_SAMPLES - 1));
    assign w_marked      = r_vpipe[2];
    assign w_all_quiet   = is_quiet(w11_in, r_w11_prev) && is_quiet(w12_in, r_w12_prev) &&
                           is_quiet(w21_in, r_w21_prev) && is_quiet(w22_in, r_w22_prev);
    assign w_conv_hit    = (r_state == S_TRAIN) && w_marked && r_have_prev && w_all_quiet &&
                           (r_quiet == QW'(CONV_CNT - 1));
    assign w_abort_taken = abort && (r_state == S_CLEAR1 || r_state == S_CLEAR2 || r_state == S_TRAIN);
    assign w_mu_half     = r_mu_cur >>> 1;
    assign w_mu_next     = (w_mu_half < $signed(MU_MIN)) ? $signed(MU_MIN) : w_mu_half;

    always_comb begin
        // NOTE: default first, so no path through the case can infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_CLEAR1;
            S_CLEAR1: w_state_nxt = abort ? S_DRAIN : S_CLEAR2;
            S_CLEAR2: w_state_nxt = abort ? S_DRAIN : S_TRAIN;
            S_TRAIN:  if (abort || w_conv_hit || w_max_hit) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (r_drain_cnt == 2'd2) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
        end
    end

    // Sample/learning-rate path: mu is captured with the sample and issued one cycle behind it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_core_rst <= 1'b0;
            r_s_vld    <= 1'b0;
            r_core_s1  <= '0;
            r_core_s2  <= '0;
            r_mu_hold  <= '0;
            r_core_mu  <= '0;
            r_vpipe    <= '0;
        end else begin
            r_core_rst <= w_start;
            r_s_vld    <= w_accept;
            r_core_s1  <= w_accept ? s1_in : '0;
            r_core_s2  <= w_accept ? s2_in : '0;
            if (w_accept) r_mu_hold <= r_mu_cur;
            r_core_mu  <= r_s_vld ? r_mu_hold : '0;
            r_vpipe    <= {r_vpipe[1:0], r_s_vld};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample_cnt <= '0;
            r_mu_cur     <= $signed(MU_INIT);
            r_decay      <= '0;
            r_quiet      <= '0;
            r_have_prev  <= 1'b0;
            r_converged  <= 1'b0;
            r_w11_prev   <= '0;
            r_w12_prev   <= '0;
            r_w21_prev   <= '0;
            r_w22_prev   <= '0;
        end else if (w_start) begin
            r_sample_cnt <= '0;
            r_mu_cur     <= $signed(MU_INIT);
            r_decay      <= '0;
            r_quiet      <= '0;
            r_have_prev  <= 1'b0;
            r_converged  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sample_cnt <= r_sample_cnt + 17'd1;
                if (r_decay == DW'(DECAY_LEN - 1)) begin
                    r_decay  <= '0;
                    r_mu_cur <= w_mu_next;
                end else begin
                    r_decay  <= r_decay + DW'(1);
                end
            end
            // The first update after a clear has no predecessor and only seeds w_prev.
            if (w_marked) begin
                r_w11_prev  <= w11_in;
                r_w12_prev  <= w12_in;
                r_w21_prev  <= w21_in;
                r_w22_prev  <= w22_in;
                r_have_prev <= 1'b1;
                if (r_have_prev) r_quiet <= w_all_quiet ? r_quiet + QW'(1) : '0;
            end
            if (w_abort_taken)   r_converged <= 1'b0;
            else if (w_conv_hit) r_converged <= 1'b1;
        end
    end

    assign in_ready   = (r_state == S_TRAIN);
    assign busy       = (r_state == S_CLEAR1) || (r_state == S_CLEAR2) ||
                        (r_state == S_TRAIN)  || (r_state == S_DRAIN);
    assign done       = (r_state == S_DONE);
    assign core_rst   = r_core_rst;
    assign core_s1    = r_core_s1;
    assign core_s2    = r_core_s2;
    assign core_mu1   = r_core_mu;
    assign core_mu2   = r_core_mu;
    assign converged  = r_converged;
    assign sample_cnt = r_sample_cnt;
    assign mu_cur     = r_mu_cur;
endmodule

// File: tb/tb_pca_train_ctrl.sv
// Bench for pca_train_ctrl: table-driven start/accept sequence, random stream against a schedule model,
// plus convergence, abort, sample-limit and reset corner cases on two differently parameterised instances.
module tb_pca_train_ctrl;
    localparam logic [31:0] MU_INIT_A  = 32'h0000_0CCC;
    localparam logic [31:0] MU_MIN_A   = 32'h0000_0300;
    localparam int          DECAY_A    = 4;
    localparam int          CONV_CNT_A = 4;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic signed [31:0] s1_in = '0, s2_in = '0;
    logic signed [31:0] w11 = '0, w12 = '0, w21 = '0, w22 = '0;
    logic w_change = 1'b0;

    logic               a_in_ready, a_core_rst, a_busy, a_done, a_converged;
    logic signed [31:0] a_core_s1, a_core_s2, a_core_mu1, a_core_mu2;
    logic        [16:0] a_sample_cnt;
    logic        [31:0] a_mu_cur;
    logic               b_in_ready, b_core_rst, b_busy, b_done, b_converged;
    logic signed [31:0] b_core_s1, b_core_s2, b_core_mu1, b_core_mu2;
    logic        [16:0] b_sample_cnt;
    logic        [31:0] b_mu_cur;

    pca_train_ctrl #(.MU_INIT(MU_INIT_A), .MU_MIN(MU_MIN_A), .DECAY_LEN(DECAY_A),
                     .MAX_SAMPLES(4096), .CONV_TH(32'h10), .CONV_CNT(CONV_CNT_A)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .s1_in(s1_in), .s2_in(s2_in), .in_valid(in_valid), .in_ready(a_in_ready),
        .w11_in(w11), .w12_in(w12), .w21_in(w21), .w22_in(w22),
        .core_rst(a_core_rst), .core_s1(a_core_s1), .core_s2(a_core_s2),
        .core_mu1(a_core_mu1), .core_mu2(a_core_mu2), .busy(a_busy), .done(a_done),
        .converged(a_converged), .sample_cnt(a_sample_cnt), .mu_cur(a_mu_cur));

    pca_train_ctrl #(.MAX_SAMPLES(8)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .s1_in(s1_in), .s2_in(s2_in), .in_valid(in_valid), .in_ready(b_in_ready),
        .w11_in(w11), .w12_in(w12), .w21_in(w21), .w22_in(w22),
        .core_rst(b_core_rst), .core_s1(b_core_s1), .core_s2(b_core_s2),
        .core_mu1(b_core_mu1), .core_mu2(b_core_mu2), .busy(b_busy), .done(b_done),
        .converged(b_converged), .sample_cnt(b_sample_cnt), .mu_cur(b_mu_cur));

    always #5 clk = ~clk;

    // Stand-in for the core's weights: either frozen or moving well above the threshold every cycle.
    always @(negedge clk) begin
        if (w_change) begin
            w11 = w11 + 32'sh100;
            w12 = w12 - 32'sh100;
            w21 = w21 + 32'sh200;
            w22 = w22 + 32'sh180;
        end
    end

    int n_vec = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check(name, {31'd0, act}, {31'd0, exp});
    endtask

    // Learning rate after n accepts: halve once per DECAY_A accepts, never below the floor.
    function automatic logic [31:0] mu_after(input int n);
        int          steps;
        logic [31:0] m;
        steps = (n < 0) ? 0 : n / DECAY_A;
        m = (steps > 31) ? 32'd0 : (MU_INIT_A >> steps);
        return (m < MU_MIN_A) ? MU_MIN_A : m;
    endfunction

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the first TRAIN cycle.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_b("ready_after_start", a_in_ready, 1'b1);
        check_b("conv_clear_on_start", a_converged, 1'b0);
    endtask

    int          m_n;
    logic        m_prev;
    logic [31:0] m_prev_mu;

    task automatic run_stream(input int ncyc, input int pct);
        logic        v;
        logic [31:0] a, b;
        for (int c = 0; c < ncyc; c++) begin
            v = ($urandom_range(0, 99) < pct);
            a = $urandom;
            b = $urandom;
            in_valid = v;
            s1_in    = a;
            s2_in    = b;
            @(negedge clk);
            if (v) m_n++;
            check_b("stream_ready", a_in_ready, 1'b1);
            check("stream_s1", a_core_s1, v ? a : 32'd0);
            check("stream_s2", a_core_s2, v ? b : 32'd0);
            check("stream_mu1", a_core_mu1, m_prev ? m_prev_mu : 32'd0);
            check("stream_mu2", a_core_mu2, m_prev ? m_prev_mu : 32'd0);
            check("stream_cnt", 32'(a_sample_cnt), 32'(m_n));
            check("stream_mu_cur", a_mu_cur, mu_after(m_n));
            m_prev    = v;
            m_prev_mu = mu_after(m_n - 1);
        end
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic        start, valid;
        logic [31:0] s1, s2;
        logic        e_rst, e_ready, e_busy;
        logic [31:0] e_s1, e_s2, e_mu;
        logic [16:0] e_cnt;
    } vec_t;

    vec_t tbl[10];
    int   k;
    int   conv_exp_cnt;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h0, 32'h0,               1'b1, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0,   17'd0};
        tbl[1] = '{1'b0, 1'b0, 32'h0, 32'h0,               1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'h0,   17'd0};
        tbl[2] = '{1'b0, 1'b0, 32'h0, 32'h0,               1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        32'h0,   17'd0};
        tbl[3] = '{1'b0, 1'b1, 32'h0001_1111, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b1, 32'h0001_1111, 32'hFFFF_FFFB, 32'h0,   17'd1};
        tbl[4] = '{1'b0, 1'b0, 32'h0, 32'h0,               1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        32'hCCC, 17'd1};
        tbl[5] = '{1'b0, 1'b0, 32'h0, 32'h0,               1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        32'h0,   17'd1};
        tbl[6] = '{1'b0, 1'b1, 32'h0000_2222, 32'h7FFF_0000, 1'b0, 1'b1, 1'b1, 32'h0000_2222, 32'h7FFF_0000, 32'h0,   17'd2};
        tbl[7] = '{1'b0, 1'b1, 32'h8000_0001, 32'h0000_3333, 1'b0, 1'b1, 1'b1, 32'h8000_0001, 32'h0000_3333, 32'hCCC, 17'd3};
        tbl[8] = '{1'b0, 1'b0, 32'h0, 32'h0,               1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        32'hCCC, 17'd3};
        tbl[9] = '{1'b0, 1'b0, 32'h0, 32'h0,               1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        32'h0,   17'd3};

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        check_b("rst_ready", a_in_ready, 1'b0);
        check_b("rst_core_rst", a_core_rst, 1'b0);
        check_b("rst_busy", a_busy, 1'b0);
        check_b("rst_done", a_done, 1'b0);
        check_b("rst_conv", a_converged, 1'b0);
        check("rst_s1", a_core_s1, 32'd0);
        check("rst_mu1", a_core_mu1, 32'd0);
        check("rst_cnt", 32'(a_sample_cnt), 32'd0);
        check("rst_mu_cur", a_mu_cur, MU_INIT_A);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Start plus three gapped accepts, one cycle per table row.
        for (int i = 0; i < 10; i++) begin
            start    = tbl[i].start;
            in_valid = tbl[i].valid;
            s1_in    = tbl[i].s1;
            s2_in    = tbl[i].s2;
            @(negedge clk);
            check_b($sformatf("tbl%0d_core_rst", i), a_core_rst, tbl[i].e_rst);
            check_b($sformatf("tbl%0d_ready", i), a_in_ready, tbl[i].e_ready);
            check_b($sformatf("tbl%0d_busy", i), a_busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_s1", i), a_core_s1, tbl[i].e_s1);
            check($sformatf("tbl%0d_s2", i), a_core_s2, tbl[i].e_s2);
            check($sformatf("tbl%0d_mu1", i), a_core_mu1, tbl[i].e_mu);
            check($sformatf("tbl%0d_mu2", i), a_core_mu2, tbl[i].e_mu);
            check($sformatf("tbl%0d_cnt", i), 32'(a_sample_cnt), 32'(tbl[i].e_cnt));
        end
        start = 1'b0;
        in_valid = 1'b0;

        // Schedule: 20 full-rate accepts, then a random stream with gaps.
        pulse_reset();
        w_change = 1'b1;
        do_start();
        m_n = 0;
        m_prev = 1'b0;
        m_prev_mu = '0;
        run_stream(20, 100);
        run_stream(300, 70);

        // Reset mid-TRAIN takes effect asynchronously, and nothing restarts without start.
        in_valid = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_b("midrst_ready", a_in_ready, 1'b0);
        check_b("midrst_busy", a_busy, 1'b0);
        check("midrst_s1", a_core_s1, 32'd0);
        check("midrst_mu1", a_core_mu1, 32'd0);
        check("midrst_cnt", 32'(a_sample_cnt), 32'd0);
        check("midrst_mu_cur", a_mu_cur, MU_INIT_A);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_b("postrst_ready", a_in_ready, 1'b0);
            check_b("postrst_core_rst", a_core_rst, 1'b0);
        end
        in_valid = 1'b0;

        // Convergence with frozen weights: the (CONV_CNT+1)-th update declares it; an update is
        // judged 4 edges after its accept, during which full-rate accepts continue.
        w_change = 1'b0;
        pulse_reset();
        do_start();
        conv_exp_cnt = (CONV_CNT_A + 1) + 4;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_converged) break;
        end
        in_valid = 1'b0;
        check_b("conv_reached", a_converged, 1'b1);
        check("conv_cnt", 32'(a_sample_cnt), 32'(conv_exp_cnt));
        check_b("conv_ready_low", a_in_ready, 1'b0);
        check_b("conv_busy", a_busy, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_b($sformatf("conv_done_%0d", i), a_done, i == 3);
            check_b($sformatf("conv_busy_%0d", i), a_busy, i < 3);
        end
        check_b("conv_held_idle", a_converged, 1'b1);

        // Abort on the very edge the quiet counter would complete; start during DRAIN is ignored.
        pulse_reset();
        do_start();
        for (int i = 1; i <= conv_exp_cnt; i++) begin
            in_valid = 1'b1;
            abort    = (i == conv_exp_cnt);
            @(negedge clk);
        end
        in_valid = 1'b0;
        abort    = 1'b0;
        check_b("abort_conv", a_converged, 1'b0);
        check_b("abort_ready", a_in_ready, 1'b0);
        check_b("abort_busy", a_busy, 1'b1);
        check("abort_cnt", 32'(a_sample_cnt), 32'(conv_exp_cnt));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_b("drain_start_busy", a_busy, 1'b1);
        check_b("drain_start_rst", a_core_rst, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_b("abort_done", a_done, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_b("abort_idle_busy", a_busy, 1'b0);
            check_b("abort_idle_conv", a_converged, 1'b0);
            check_b("abort_idle_rst", a_core_rst, 1'b0);
        end

        // Sample limit of 8 with moving weights on the second instance.
        w_change = 1'b1;
        pulse_reset();
        do_start();
        k = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!b_in_ready) break;
            k++;
        end
        in_valid = 1'b0;
        check_b("max_ready_drop", b_in_ready, 1'b0);
        check("max_ready_cycles", 32'(k), 32'd7);
        check("max_cnt", 32'(b_sample_cnt), 32'd8);
        check_b("max_conv", b_converged, 1'b0);
        check_b("max_done_early", b_done, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_b($sformatf("max_done_%0d", i), b_done, i == 3);
            check_b($sformatf("max_busy_%0d", i), b_busy, i < 3);
        end
        check_b("max_conv_idle", b_converged, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pca_train_ctrl.md
# pca_train_ctrl

Training sequencer for the two-component Sanger GHA PCA core (16.16 fixed point, free-running, no enable). It accepts a valid/ready sample stream and clears the core on start. It gates samples into the core with a learning-rate schedule, monitors the four eigenvector weights for convergence, and drains the core pipeline before signalling completion.

## Interface
- MU_INIT, 32'h00000CCC, initial learning rate (16.16, about 0.05), applied to both PCs
- MU_MIN, 32'h00000040, learning-rate floor (16.16)
- DECAY_LEN, 1024, accepted samples per learning-rate halving step
- MAX_SAMPLES, 65536, hard limit on accepted samples per run
- CONV_TH, 32'h00000010, per-weight change threshold (16.16)
- CONV_CNT, 64, consecutive quiet updates that declare convergence
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  begin a run; honoured only in IDLE
- abort  in  1  end the current run early
- s1_in, s2_in  in  32 signed  sample pair
- in_valid  in  1  sample pair valid
- in_ready  out  1  sample accepted when in_valid & in_ready
- w11_in, w12_in, w21_in, w22_in  in  32 signed  weights from the core
- core_rst  out  1  registered clear pulse to the core's reset
- core_s1, core_s2  out  32 signed  samples to the core
- core_mu1, core_mu2  out  32 signed  learning rates to the core
- busy  out  1  high in CLEAR, TRAIN and DRAIN
- done  out  1  one-cycle pulse on entering DONE
- converged  out  1  run ended by convergence; held until the next start
- sample_cnt  out  17  accepted samples in the current run
- mu_cur  out  32  current scheduled learning rate

## Operation
- States:
  - IDLE: start -> CLEAR.
  - CLEAR: 2 cycles. core_rst is 1 in the first cycle and 0 in the second.
  - TRAIN: in_ready = 1. Exit to DRAIN on convergence, on sample_cnt reaching MAX_SAMPLES (on the accept that makes it so), or on abort.
  - DRAIN: 3 cycles, in_ready = 0, mu = 0.
  - DONE: 1 cycle, done = 1, then IDLE.
- start is ignored outside IDLE. abort in CLEAR or TRAIN goes to DRAIN. abort in IDLE, DRAIN or DONE is ignored. Abort forces converged = 0.
- On start: sample_cnt <= 0, mu_cur <= MU_INIT, decay counter <= 0, quiet counter <= 0, converged <= 0.
- Each accept:
  - core_s1/core_s2 <= s1_in/s2_in, and sample_cnt increments.
  - In each cycle with no accept, core_s1/core_s2 <= 0.
  - core_mu1 = core_mu2 = mu_cur on the cycle after the accept, else 0. With mu = 0 the core's weights hold.
- Schedule:
  - The decay counter counts accepts and wraps at DECAY_LEN-1.
  - On the wrapping accept, mu_cur <= max(mu_cur >>> 1, MU_MIN). The new value applies from the next accept.
- Convergence:
  - A 3-stage valid pipe marks the cycle on which an accepted sample's weight update appears on w*_in.
  - On each marked cycle, compute |w_in - w_prev| for all four weights using 33-bit signed subtraction. Register w_prev on every marked cycle.
  - If all four changes are < CONV_TH, the quiet counter increments; otherwise it resets to 0.
  - The first marked cycle after CLEAR only loads w_prev.
  - When the quiet counter reaches CONV_CNT: converged <= 1 and the state goes to DRAIN.
- If convergence and sample_cnt reaching MAX_SAMPLES happen in the same cycle, converged = 1.
- If abort occurs in the same cycle as either, abort wins and converged = 0.

## Timing
- Reset values: state IDLE, in_ready 0, core_rst 0, core_s*/core_mu* 0, busy 0, done 0, converged 0, sample_cnt 0, mu_cur MU_INIT.
- Accept at edge E0:
  - core_s valid after E0.
  - core_mu nonzero after E1 (one cycle after core_s, so mu aligns with the core's mixed sample).
  - Weight update visible on w*_in after E3.
- start at edge T: busy is high after T, core_rst is high for the cycle after T, and in_ready rises after T+2.
- DRAIN is exactly 3 cycles, so the last accepted sample's update lands before done.
- done is high for the one cycle after the last DRAIN cycle. busy falls in that same cycle.
- Back-to-back accepts at full rate are supported, with no bubbles.

## Test plan
- Reset mid-TRAIN -> all outputs return to their reset values within the reset cycle. in_ready = 0 and core_rst = 0 until the next start.
- start, then 3 accepts with gaps -> core_rst pulses 1 cycle; core_mu equals 0x0CCC exactly one cycle after each nonzero core_s and is 0 elsewhere; sample_cnt = 3.
- DECAY_LEN = 4, MU_MIN = 0x0300, 20 accepts -> mu_cur steps 0x0CCC, 0x0666, 0x0333, 0x0300 (floor) on accepts 4, 8 and 12, then holds.
- Weights model held constant, CONV_CNT = 4 -> converged = 1 after the 5th marked update, followed by 3 DRAIN cycles and a done pulse.
- MAX_SAMPLES = 8, weights keep changing -> in_ready drops after accept 8, converged = 0, done pulses 4 cycles later.
- abort in the same cycle the quiet counter hits CONV_CNT -> DRAIN entered, converged = 0; start during DRAIN is ignored.
